trena_periodica: RTL and testbench
==================================

Name: trena_periodica

Overview:
Parametrised ultrasonic ranging controller, successor to the single-shot trena datapath/control pair.
- Generates the sensor trigger and times the echo.
- Converts echo width to centimetres, averages 2^N_LOG2 samples per measurement, and converts the result to BCD.
- Hands the result to a downstream consumer (serial transmitter) over a valid/accept handshake.
- Supports single-shot and continuous periodic modes, with echo timeout and out-of-range detection.

Parameters:
TRIGGER_CICLOS, 500, trigger pulse width in clock cycles (10 us at 50 MHz)
CICLOS_POR_CM, 2941, echo-high clock cycles per centimetre
TIMEOUT_CICLOS, 1500000, max cycles waiting for echo rise, and max echo-high width
PERIODO_CICLOS, 5000000, minimum cycles between consecutive trigger rising edges
N_LOG2, 2, log2 of samples averaged per measurement
DIGITOS, 3, BCD digits of result; W = clog2(10**DIGITOS) binary width internally

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
mensurar  in  1  single-cycle start pulse (already edge-detected upstream)
modo  in  1  0 = single-shot, 1 = continuous periodic
echo  in  1  sensor echo, asynchronous; 2-FF synchronised internally
dado_aceito  in  1  consumer accepts result
trigger  out  1  sensor trigger
distancia  out  4*DIGITOS  BCD result, digit 0 in [3:0]
dado_valido  out  1  result available
fora_alcance  out  1  last result saturated
erro_timeout  out  1  last measurement aborted by timeout
pronto  out  1  one-cycle pulse at the end of each measurement
db_estado  out  4  current FSM state code

Behaviour:
- Reset (reset=0, async): all outputs 0, distancia=0, all counters/accumulators 0, FSM=OCIOSO(0). Reset mid-operation aborts immediately; no partial result is kept.
- FSM states and codes:
  - OCIOSO(0): wait for mensurar=1, or modo=1, then -> DISPARO. Clears the accumulator and sample count. mensurar is ignored in every other state.
  - DISPARO(1): trigger=1 for exactly TRIGGER_CICLOS cycles, then -> ESPERA_ECHO. The period counter restarts at 0 on entry.
  - ESPERA_ECHO(2): on synchronised echo rise -> MEDE. If TIMEOUT_CICLOS cycles elapse first -> ABORTA.
  - MEDE(3):
    - The sub-counter counts 0..CICLOS_POR_CM-1; the cm counter increments on wrap. The result is floor division.
    - The cm counter saturates at 10**DIGITOS-1 and sets an internal saturation flag.
    - On echo fall -> ACUMULA. If echo-high exceeds TIMEOUT_CICLOS -> ABORTA.
  - ACUMULA(4): accumulator += cm, sample count++. If count = 2^N_LOG2 -> MEDIA, else -> INTERVALO.
  - INTERVALO(5): wait until period counter = PERIODO_CICLOS-1, then -> DISPARO. This applies between samples and between measurements, so trigger rising edges are never closer than PERIODO_CICLOS.
  - MEDIA(6): result = accumulator >> N_LOG2 (floor), one cycle, -> CONVERTE. The accumulator width is W+N_LOG2, so there is no overflow.
  - CONVERTE(7): sequential double-dabble, exactly W cycles, -> DISPONIVEL.
  - DISPONIVEL(8):
    - On entry: distancia loads the BCD value, dado_valido=1, fora_alcance=saturation flag of any sample, erro_timeout=0.
    - distancia is held stable while dado_valido=1.
    - The transfer occurs on the first cycle with dado_valido=1 and dado_aceito=1, including the entry cycle.
    - On transfer: dado_valido=0 and pronto=1 for that one cycle. Then -> INTERVALO if modo=1, else -> OCIOSO.
    - A consumer stall blocks the next trigger; the period counter keeps running, so the next trigger occurs at max(period expiry, transfer+1 cycle).
  - ABORTA(9): one cycle. erro_timeout=1, pronto=1, fora_alcance=0, distancia unchanged, no dado_valido. Then -> INTERVALO if modo=1, else -> OCIOSO.
- erro_timeout and fora_alcance hold until the next measurement completes.
- modo is sampled only at the end of a measurement. Dropping modo to 0 mid-measurement finishes the current measurement, then -> OCIOSO.
- Echo path: 2-cycle synchroniser latency applies equally to rise and fall, so width is preserved.
- Unused FSM codes -> OCIOSO.

Test Plan:
All scenarios use TRIGGER_CICLOS=4, CICLOS_POR_CM=10, TIMEOUT_CICLOS=200, PERIODO_CICLOS=300, N_LOG2=1, DIGITOS=3, with dado_aceito held at 1 unless stated.
1. Single-shot, modo=0:
   - Stimulus: mensurar pulse; echo high 125 cycles for both samples.
   - Required: trigger high exactly 4 cycles, twice, rises 300 cycles apart; distancia=0x012; dado_valido for 1 cycle; one pronto pulse; return to state 0.
2. Averaging:
   - Stimulus: echo widths 100 and 135 cycles.
   - Required: samples 10 and 13, floor(23/2) -> distancia=0x011, fora_alcance=0.
3. Timeout:
   - Stimulus: no echo after the trigger.
   - Required: exactly 200 cycles after the trigger falls, ABORTA; erro_timeout=1 and a single pronto pulse; distancia keeps its previous value; dado_valido stays 0. Repeat with echo stuck high: the same response.
4. Saturation:
   - Stimulus: DIGITOS=1; echo width 150 cycles for both samples.
   - Required: distancia=0x9, fora_alcance=1.
5. Continuous mode:
   - Stimulus: modo=1 with dado_aceito=1.
   - Required: trigger rises every 300 cycles indefinitely. Hold dado_aceito=0 for 1000 cycles: distancia stable, no new trigger until 1 cycle after acceptance. Drop modo mid-sample: the measurement completes, then OCIOSO.
6. Reset mid-MEDE:
   - Stimulus: reset=0 while echo is high.
   - Required: trigger, dado_valido and distancia go to 0 immediately (asynchronously); db_estado=0. After release, no activity until mensurar.

Source files
------------

// File: rtl/trena_periodica.sv
// Periodic ultrasonic ranging controller: trigger generation, echo timing, averaging,
// binary-to-BCD conversion and valid/accept hand-off of the result.
module trena_periodica #(
  parameter int unsigned TRIGGER_CICLOS = 500,
  parameter int unsigned CICLOS_POR_CM  = 2941,
  parameter int unsigned TIMEOUT_CICLOS = 1500000,
  parameter int unsigned PERIODO_CICLOS = 5000000,
  parameter int unsigned N_LOG2         = 2,
  parameter int unsigned DIGITOS        = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mensurar,
  input  logic                   modo,
  input  logic                   echo,
  input  logic                   dado_aceito,
  output logic                   trigger,
  output logic [4*DIGITOS-1:0]   distancia,
  output logic                   dado_valido,
  output logic                   fora_alcance,
  output logic                   erro_timeout,
  output logic                   pronto,
  output logic [3:0]             db_estado
);

  localparam int unsigned CM_MAX = 10**DIGITOS - 1;
  localparam int unsigned W      = $clog2(10**DIGITOS);
  localparam int unsigned AW     = W + N_LOG2;
  localparam int unsigned NW     = N_LOG2 + 1;
  localparam int unsigned BW     = 4 * DIGITOS;
  localparam int unsigned SW     = $clog2(CICLOS_POR_CM + 1);
  localparam int unsigned PW     = $clog2(PERIODO_CICLOS + 1);
  localparam int unsigned CW     = $clog2(TIMEOUT_CICLOS + TRIGGER_CICLOS + W + 2);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    DISPARO     = 4'd1,
    ESPERA_ECHO = 4'd2,
    MEDE        = 4'd3,
    ACUMULA     = 4'd4,
    INTERVALO   = 4'd5,
    MEDIA       = 4'd6,
    CONVERTE    = 4'd7,
    DISPONIVEL  = 4'd8,
    ABORTA      = 4'd9
  } estado_t;

  estado_t         estado_q, estado_d;
  logic            echo_s1_q, echo_s2_q, echo_s3_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   per_q, per_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic [W-1:0]    cm_q, cm_d;
  logic            sat_q, sat_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [NW-1:0]   nam_q, nam_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   adj;
  logic            trigger_q, trigger_d;
  logic [BW-1:0]   dist_q, dist_d;
  logic            valido_q, valido_d;
  logic            fora_q, fora_d;
  logic            erro_q, erro_d;
  logic            pronto_q, pronto_d;
  logic            rise;
  logic            per_fim;

  assign rise    = echo_s2_q & ~echo_s3_q;
  assign per_fim = (per_q == PW'(PERIODO_CICLOS - 1));

  always_comb begin
    // double-dabble correction: add 3 to every digit >= 5 before the shift
    for (int i = 0; i < int'(DIGITOS); i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    per_d     = per_fim ? per_q : per_q + PW'(1);
    sub_d     = sub_q;
    cm_d      = cm_q;
    sat_d     = sat_q;
    acc_d     = acc_q;
    nam_d     = nam_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    dist_d    = dist_q;
    valido_d  = valido_q;
    fora_d    = fora_q;
    erro_d    = erro_q;
    pronto_d  = 1'b0;
    trigger_d = 1'b0;

    case (estado_q)
      OCIOSO: begin
        acc_d = '0;
        nam_d = '0;
        sat_d = 1'b0;
        if (mensurar || modo) estado_d = DISPARO;
      end
      DISPARO: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TRIGGER_CICLOS - 1)) begin
          estado_d = ESPERA_ECHO;
          cnt_d    = '0;
        end
      end
      ESPERA_ECHO: begin
        cnt_d = cnt_q + CW'(1);
        if (rise) begin
          // the first synchronised high cycle already counts towards the width
          estado_d = MEDE;
          cnt_d    = CW'(1);
          sub_d    = (CICLOS_POR_CM == 1) ? '0 : SW'(1);
          cm_d     = (CICLOS_POR_CM == 1) ? W'(1) : '0;
        end else if (cnt_q == CW'(TIMEOUT_CICLOS - 1)) begin
          estado_d = ABORTA;
        end
      end
      MEDE: begin
        if (!echo_s2_q) begin
          estado_d = ACUMULA;
        end else if (cnt_q == CW'(TIMEOUT_CICLOS)) begin
          estado_d = ABORTA;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (sub_q == SW'(CICLOS_POR_CM - 1)) begin
            sub_d = '0;
            if (cm_q == W'(CM_MAX)) sat_d = 1'b1;
            else                    cm_d  = cm_q + W'(1);
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
      end
      ACUMULA: begin
        acc_d = acc_q + AW'(cm_q);
        nam_d = nam_q + NW'(1);
        if (nam_q == NW'(2**N_LOG2 - 1)) estado_d = MEDIA;
        else                             estado_d = INTERVALO;
      end
      INTERVALO: begin
        if (per_fim) estado_d = DISPARO;
      end
      MEDIA: begin
        bin_d    = W'(acc_q >> N_LOG2);
        bcd_d    = '0;
        cnt_d    = '0;
        estado_d = CONVERTE;
      end
      CONVERTE: begin
        bcd_d = BW'({adj, bin_q[W-1]});
        bin_d = W'({bin_q, 1'b0});
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          estado_d = DISPONIVEL;
          dist_d   = BW'({adj, bin_q[W-1]});
          valido_d = 1'b1;
          fora_d   = sat_q;
          erro_d   = 1'b0;
        end
      end
      DISPONIVEL: begin
        if (dado_aceito) begin
          valido_d = 1'b0;
          pronto_d = 1'b1;
          acc_d    = '0;
          nam_d    = '0;
          sat_d    = 1'b0;
          // a stalled consumer may already have let the period expire
          if (modo) estado_d = per_fim ? DISPARO : INTERVALO;
          else      estado_d = OCIOSO;
        end
      end
      ABORTA: begin
        acc_d    = '0;
        nam_d    = '0;
        sat_d    = 1'b0;
        estado_d = modo ? INTERVALO : OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase

    if (estado_d == ABORTA) begin
      erro_d   = 1'b1;
      pronto_d = 1'b1;
      fora_d   = 1'b0;
    end
    if (estado_d == DISPARO && estado_q != DISPARO) begin
      per_d = '0;
      cnt_d = '0;
    end
    trigger_d = (estado_d == DISPARO);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
      cnt_q     <= '0;
      per_q     <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      sat_q     <= 1'b0;
      acc_q     <= '0;
      nam_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      trigger_q <= 1'b0;
      dist_q    <= '0;
      valido_q  <= 1'b0;
      fora_q    <= 1'b0;
      erro_q    <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      sat_q     <= sat_d;
      acc_q     <= acc_d;
      nam_q     <= nam_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      trigger_q <= trigger_d;
      dist_q    <= dist_d;
      valido_q  <= valido_d;
      fora_q    <= fora_d;
      erro_q    <= erro_d;
      pronto_q  <= pronto_d;
    end
  end

  assign trigger      = trigger_q;
  assign distancia    = dist_q;
  assign dado_valido  = valido_q;
  assign fora_alcance = fora_q;
  assign erro_timeout = erro_q;
  assign pronto       = pronto_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_trena_periodica.sv
// Bench for trena_periodica: directed scenarios plus random echo widths, checked
// against an arithmetic model of distance = floor(mean(min(width/10, max))).
module tb_trena_periodica;

  localparam int CPC = 10;

  logic        clock = 1'b0;
  logic        reset, mensurar, modo, echo, dado_aceito;
  logic        trigger, dado_valido, fora_alcance, erro_timeout, pronto;
  logic [11:0] distancia;
  logic [3:0]  db_estado;
  logic        mensurar_s, modo_s, echo_s, aceito_s;
  logic        trigger_s, valido_s, fora_s, erro_s, pronto_s;
  logic [3:0]  dist_s;
  logic [3:0]  estado_s;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  trena_periodica #(.TRIGGER_CICLOS(4), .CICLOS_POR_CM(10), .TIMEOUT_CICLOS(200),
                    .PERIODO_CICLOS(300), .N_LOG2(1), .DIGITOS(3)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .modo(modo), .echo(echo),
    .dado_aceito(dado_aceito), .trigger(trigger), .distancia(distancia),
    .dado_valido(dado_valido), .fora_alcance(fora_alcance), .erro_timeout(erro_timeout),
    .pronto(pronto), .db_estado(db_estado));

  trena_periodica #(.TRIGGER_CICLOS(4), .CICLOS_POR_CM(10), .TIMEOUT_CICLOS(200),
                    .PERIODO_CICLOS(300), .N_LOG2(1), .DIGITOS(1)) u_sat (
    .clock(clock), .reset(reset), .mensurar(mensurar_s), .modo(modo_s), .echo(echo_s),
    .dado_aceito(aceito_s), .trigger(trigger_s), .distancia(dist_s),
    .dado_valido(valido_s), .fora_alcance(fora_s), .erro_timeout(erro_s),
    .pronto(pronto_s), .db_estado(estado_s));

  // event recorder for the main instance
  longint      rise_t [0:63];
  int          rise_n = 0;
  int          pronto_n = 0;
  int          valid_n = 0;
  longint      fall_t = 0;
  longint      pronto_t = 0;
  logic [11:0] valid_dist = '0;
  logic        trig_prev = 1'b0;

  always @(negedge clock) begin
    trig_prev <= trigger;
    if (trigger === 1'b1 && trig_prev !== 1'b1 && rise_n < 64) begin
      rise_t[rise_n] <= $time;
      rise_n         <= rise_n + 1;
    end
    if (trigger !== 1'b1 && trig_prev === 1'b1) fall_t <= $time;
    if (pronto === 1'b1) begin
      pronto_n <= pronto_n + 1;
      pronto_t <= $time;
    end
    if (dado_valido === 1'b1) begin
      valid_n    <= valid_n + 1;
      valid_dist <= distancia;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cm_of(input int w, input int cmax);
    int c;
    c = w / CPC;
    return (c > cmax) ? cmax : c;
  endfunction

  function automatic logic [31:0] exp_dist(input int a, input int b);
    int avg;
    avg = (cm_of(a, 999) + cm_of(b, 999)) / 2;
    return 32'((avg / 100) % 10 * 256 + (avg / 10) % 10 * 16 + avg % 10);
  endfunction

  task automatic pulse_mensurar(input bit sel);
    if (sel) mensurar_s = 1'b1; else mensurar = 1'b1;
    @(negedge clock);
    if (sel) mensurar_s = 1'b0; else mensurar = 1'b0;
  endtask

  // wait for a trigger pulse, check its width, then return an echo of the given width
  task automatic sample(input bit sel, input int width, input int dly);
    bit ok;
    int len;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ((sel ? trigger_s : trigger) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    chk("trigger_seen", 32'(ok), 32'd1);
    if (!ok) return;
    len = 0;
    for (int i = 0; i < 100; i++) begin
      if ((sel ? trigger_s : trigger) !== 1'b1) break;
      len++;
      @(negedge clock);
    end
    chk("trigger_width", 32'(len), 32'd4);
    repeat (dly) @(negedge clock);
    if (sel) echo_s = 1'b1; else echo = 1'b1;
    repeat (width) @(negedge clock);
    if (sel) echo_s = 1'b0; else echo = 1'b0;
  endtask

  task automatic wait_pronto(input int snap);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (pronto_n > snap) begin ok = 1'b1; break; end
    end
    chk("pronto_seen", 32'(ok), 32'd1);
  endtask

  task automatic measure_single(input string tag, input int wa, input int wb);
    int rs, ps, vs;
    rs = rise_n; ps = pronto_n; vs = valid_n;
    pulse_mensurar(1'b0);
    sample(1'b0, wa, int'($urandom_range(2, 40)));
    sample(1'b0, wb, int'($urandom_range(2, 40)));
    wait_pronto(ps);
    repeat (5) @(negedge clock);
    chk({tag, "_dist"}, 32'(valid_dist), exp_dist(wa, wb));
    chk({tag, "_dist_hold"}, 32'(distancia), exp_dist(wa, wb));
    chk({tag, "_valid_cycles"}, 32'(valid_n - vs), 32'd1);
    chk({tag, "_pronto_pulses"}, 32'(pronto_n - ps), 32'd1);
    chk({tag, "_rise_gap"}, 32'((rise_t[rs + 1] - rise_t[rs]) / 10), 32'd300);
    chk({tag, "_fora"}, 32'(fora_alcance), 32'd0);
    chk({tag, "_erro"}, 32'(erro_timeout), 32'd0);
    chk({tag, "_state"}, 32'(db_estado), 32'd0);
    repeat (400) @(negedge clock);
    chk({tag, "_idle_rises"}, 32'(rise_n - rs), 32'd2);
  endtask

  task automatic timeout_case(input string tag, input logic [31:0] prev);
    int ps, vs;
    ps = pronto_n; vs = valid_n;
    pulse_mensurar(1'b0);
    wait_pronto(ps);
    repeat (20) @(negedge clock);
    chk({tag, "_gap"}, 32'((pronto_t - fall_t) / 10), 32'd200);
    chk({tag, "_erro"}, 32'(erro_timeout), 32'd1);
    chk({tag, "_pronto_pulses"}, 32'(pronto_n - ps), 32'd1);
    chk({tag, "_no_valid"}, 32'(valid_n - vs), 32'd0);
    chk({tag, "_dist_kept"}, 32'(distancia), prev);
    chk({tag, "_fora"}, 32'(fora_alcance), 32'd0);
    chk({tag, "_state"}, 32'(db_estado), 32'd0);
  endtask

  initial begin
    int rs, rs2, ps, wa, wb, wc, wd;
    bit ok, stable, held;
    logic [11:0] d0;
    longint ta;

    reset = 1'b0; mensurar = 1'b0; modo = 1'b0; echo = 1'b0; dado_aceito = 1'b1;
    mensurar_s = 1'b0; modo_s = 1'b0; echo_s = 1'b0; aceito_s = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_dist", 32'(distancia), 32'd0);
    chk("rst_valid", 32'(dado_valido), 32'd0);
    chk("rst_fora", 32'(fora_alcance), 32'd0);
    chk("rst_erro", 32'(erro_timeout), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_state", 32'(db_estado), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single shot and averaging
    measure_single("t1", 125, 125);
    chk("t1_literal", 32'(distancia), 32'h012);
    measure_single("t2", 100, 135);
    chk("t2_literal", 32'(distancia), 32'h011);

    // timeouts: no echo, then echo stuck high
    timeout_case("t3_noecho", 32'h011);
    echo = 1'b1;
    repeat (5) @(negedge clock);
    timeout_case("t3_stuck", 32'h011);
    echo = 1'b0;
    repeat (5) @(negedge clock);

    // saturation with a single digit
    pulse_mensurar(1'b1);
    sample(1'b1, 150, 5);
    sample(1'b1, 150, 5);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (valido_s === 1'b1) begin ok = 1'b1; break; end
    end
    chk("t4_valid_seen", 32'(ok), 32'd1);
    chk("t4_dist", 32'(dist_s), 32'((cm_of(150, 9) + cm_of(150, 9)) / 2));
    chk("t4_fora", 32'(fora_s), 32'd1);
    chk("t4_erro", 32'(erro_s), 32'd0);

    // continuous mode with random widths
    rs = rise_n;
    modo = 1'b1;
    for (int m = 0; m < 3; m++) begin
      ps = pronto_n;
      wa = int'($urandom_range(1, 190));
      wb = int'($urandom_range(1, 190));
      sample(1'b0, wa, int'($urandom_range(1, 50)));
      sample(1'b0, wb, int'($urandom_range(1, 50)));
      wait_pronto(ps);
      chk("t5_dist", 32'(valid_dist), exp_dist(wa, wb));
      chk("t5_erro", 32'(erro_timeout), 32'd0);
      chk("t5_fora", 32'(fora_alcance), 32'd0);
    end

    // consumer stall
    dado_aceito = 1'b0;
    wa = int'($urandom_range(1, 190));
    wb = int'($urandom_range(1, 190));
    sample(1'b0, wa, int'($urandom_range(1, 50)));
    sample(1'b0, wb, int'($urandom_range(1, 50)));
    for (int k = 0; k < 7; k++)
      chk("t5_rise_gap", 32'((rise_t[rs + k + 1] - rise_t[rs + k]) / 10), 32'd300);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (dado_valido === 1'b1) begin ok = 1'b1; break; end
    end
    chk("t5_stall_valid_seen", 32'(ok), 32'd1);
    d0 = distancia;
    chk("t5_stall_dist", 32'(d0), exp_dist(wa, wb));
    rs2 = rise_n;
    stable = 1'b1; held = 1'b1;
    repeat (1000) begin
      @(negedge clock);
      if (distancia !== d0) stable = 1'b0;
      if (dado_valido !== 1'b1) held = 1'b0;
    end
    chk("t5_stall_dist_stable", 32'(stable), 32'd1);
    chk("t5_stall_valid_held", 32'(held), 32'd1);
    chk("t5_stall_no_trigger", 32'(rise_n - rs2), 32'd0);
    dado_aceito = 1'b1;
    ta = $time;
    wc = int'($urandom_range(1, 190));
    wd = int'($urandom_range(1, 190));
    sample(1'b0, wc, int'($urandom_range(1, 50)));
    chk("t5_accept_to_trigger", 32'((rise_t[rs2] - ta) / 10), 32'd1);

    // modo dropped mid-measurement: finish it, then idle
    modo = 1'b0;
    ps = pronto_n;
    sample(1'b0, wd, int'($urandom_range(1, 50)));
    wait_pronto(ps);
    chk("t5_drop_dist", 32'(valid_dist), exp_dist(wc, wd));
    chk("t5_drop_gap", 32'((rise_t[rs2 + 1] - rise_t[rs2]) / 10), 32'd300);
    repeat (400) @(negedge clock);
    chk("t5_drop_rises", 32'(rise_n - rs2), 32'd2);
    chk("t5_drop_state", 32'(db_estado), 32'd0);

    // asynchronous reset during MEDE
    pulse_mensurar(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (trigger === 1'b0 && db_estado == 4'd2) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    chk("t6_reached_wait", 32'(ok), 32'd1);
    repeat (5) @(negedge clock);
    echo = 1'b1;
    repeat (40) @(negedge clock);
    chk("t6_in_mede", 32'(db_estado), 32'd3);
    chk("t6_dist_before", 32'(distancia), exp_dist(wc, wd));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_trigger", 32'(trigger), 32'd0);
    chk("t6_valid", 32'(dado_valido), 32'd0);
    chk("t6_dist", 32'(distancia), 32'd0);
    chk("t6_state", 32'(db_estado), 32'd0);
    echo = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rs = rise_n;
    repeat (400) @(negedge clock);
    chk("t6_no_activity", 32'(rise_n - rs), 32'd0);
    chk("t6_idle_state", 32'(db_estado), 32'd0);

    // recovery with random widths
    measure_single("t7", int'($urandom_range(1, 190)), int'($urandom_range(1, 190)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
